// File: rtl/shuffle_pkg.sv
// Shared definitions for the shuffle-stage nonce transfer (unloader and receiver).
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents: default nonce width shared with the unloader, and the encoding of
// the receiver's req/ack handshake FSM.
package shuffle_pkg;

  // Nonce bus width; the unloader and the receiver must agree on this.
  localparam int NONCE_WIDTH = 7;

  // Handshake FSM encoding. Two bits so a corrupted state has somewhere to
  // land that the FSM can recognise and recover from.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_ACK  = 2'd1;

endpackage : shuffle_pkg

// File: rtl/shuffle_handshake_receiver_if.sv
// Bundle of the receiver's upstream req/ack nonce bus and downstream stream.
// Latency: n/a (wires only).
// Backpressure: carried by o_handshake_recv (upstream) and i_ready (downstream).
//
// Signals (named from the receiver's point of view):
//   i_data           nonce from upstream, stable while i_handshake=1
//   i_handshake      4-phase request from upstream
//   o_handshake_recv 4-phase acknowledge to upstream
//   o_data/o_valid   FIFO head nonce and non-empty flag
//   i_ready          downstream accept
//   o_count          current FIFO occupancy
//   o_received       running count of captured nonces (16 bit, wraps)
// Modports: slave = receiver, master = the environment driving it.
interface shuffle_handshake_receiver_if
  import shuffle_pkg::*;
#(
  parameter int nonce_width  = NONCE_WIDTH,
  parameter int buffer_depth = 4
);

  localparam int count_width = $clog2(buffer_depth) + 1;

  logic [nonce_width-1:0] i_data;
  logic                   i_handshake;
  logic                   o_handshake_recv;
  logic [nonce_width-1:0] o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [count_width-1:0] o_count;
  logic [15:0]            o_received;

  modport slave (
    input  i_data,
    input  i_handshake,
    input  i_ready,
    output o_handshake_recv,
    output o_data,
    output o_valid,
    output o_count,
    output o_received
  );

  modport master (
    output i_data,
    output i_handshake,
    output i_ready,
    input  o_handshake_recv,
    input  o_data,
    input  o_valid,
    input  o_count,
    input  o_received
  );

endinterface : shuffle_handshake_receiver_if

// File: rtl/shuffle_nonce_fifo.sv
// Register-based first-word-fall-through FIFO for received nonces.
// Latency: push visible on dout/count the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
//
// Ports: clk, rst (async, active-low), push/din write side, pop/dout read side,
//        count (occupancy 0..buffer_depth), full, empty.
// buffer_depth must be a power of two >= 2 so the pointers wrap naturally.
module shuffle_nonce_fifo
  import shuffle_pkg::*;
#(
  parameter int nonce_width  = NONCE_WIDTH,
  parameter int buffer_depth = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [nonce_width-1:0]        din,
  input  logic                          pop,
  output logic [nonce_width-1:0]        dout,
  output logic [$clog2(buffer_depth):0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(buffer_depth);
  localparam logic [AW:0] DEPTH_C = AW'(buffer_depth) == '0 ? {1'b1, {AW{1'b0}}}
                                                            : (AW+1)'(buffer_depth);

  logic [nonce_width-1:0] mem [buffer_depth];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is reset too so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < buffer_depth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;

endmodule : shuffle_nonce_fifo

// File: rtl/shuffle_handshake_receiver.sv
// Receive end of the shuffle nonce transfer: 4-phase req/ack in, FWFT valid/ready stream out.
// Latency: req rise -> ack rise and req fall -> ack fall are sync_stages+1 cycles each.
// Backpressure: a full FIFO holds ack low until a slot frees; downstream stalls via i_ready.
//
// Ports: clk, rst (async, active-low), bus (slave modport of
//        shuffle_handshake_receiver_if: upstream i_data/i_handshake/o_handshake_recv,
//        downstream o_data/o_valid/i_ready, status o_count/o_received).
// Upstream's req->ack path has a single register, so req is synchronised here.
module shuffle_handshake_receiver
  import shuffle_pkg::*;
#(
  parameter int nonce_width  = NONCE_WIDTH,
  parameter int buffer_depth = 4,
  parameter int sync_stages  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  shuffle_handshake_receiver_if.slave   bus
);

  localparam int CW = $clog2(buffer_depth) + 1;

  // ---------------------------------------------------------------------------
  // Request synchroniser
  // ---------------------------------------------------------------------------
  logic [sync_stages-1:0] sync_q;
  logic                   req_s;

  if (sync_stages == 1) begin : g_sync_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= bus.i_handshake;
      end
    end
  end else begin : g_sync_many
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[sync_stages-2:0], bus.i_handshake};
      end
    end
  end

  assign req_s = sync_q[sync_stages-1];

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [nonce_width-1:0] head;
  logic [CW-1:0]          count;

  // full is the registered occupancy, so a pop this cycle cannot make room
  // for a push in the same cycle.
  assign pop = bus.i_ready & ~empty;

  shuffle_nonce_fifo #(
    .nonce_width  (nonce_width),
    .buffer_depth (buffer_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.i_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  logic [ST_W-1:0] state_q;
  logic            ack_q;
  logic [15:0]     received_q;

  // Capture only from IDLE: once in ACK a held-high req cannot push again,
  // which gives exactly one capture per req rising phase. i_data is stable
  // here because upstream holds it until it has seen ack.
  assign push = (state_q == ST_IDLE) & req_s & ~full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      received_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (push) begin
            state_q    <= ST_ACK;
            ack_q      <= 1'b1;
            received_q <= received_q + 16'd1;
          end else begin
            ack_q      <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!req_s) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end else begin
            ack_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_handshake_recv = ack_q;
  assign bus.o_data           = head;
  assign bus.o_valid          = ~empty;
  assign bus.o_count          = count;
  assign bus.o_received       = received_q;

endmodule : shuffle_handshake_receiver

// File: tb/tb_shuffle_handshake_receiver.sv
// Bench for shuffle_handshake_receiver: directed handshake scenarios plus a
// randomized transfer phase, checked every cycle against a queue model.
// The model tracks what the FIFO should hold as an ordered list of nonces.
module tb_shuffle_handshake_receiver;
  import shuffle_pkg::*;

  localparam int W     = 7;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shuffle_handshake_receiver_if #(.nonce_width(W), .buffer_depth(DEPTH)) bus ();

  shuffle_handshake_receiver #(
    .nonce_width  (W),
    .buffer_depth (DEPTH),
    .sync_stages  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFO contents as a queue, capture counter, pop log
  // ---------------------------------------------------------------------------
  logic [W-1:0] mq[$];
  logic [W-1:0] out_log[$];
  int           m_recv;
  bit           mon_en;
  bit           pop_pend;
  bit           prev_ack;
  bit           rand_rdy;
  int           max_cnt;

  task automatic model_clear();
    mq.delete();
    m_recv   = 0;
    pop_pend = 0;
    prev_ack = 0;
  endtask

  // Evaluated mid-cycle: apply what the preceding edge should have done, then
  // compare the visible outputs with the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_handshake_recv && !prev_ack) begin
        // A new capture must only have been accepted with a free slot as seen
        // before that edge (a same-edge pop does not count).
        check("push_while_full", 32'(mq.size() < DEPTH), 32'd1);
      end
      if (pop_pend) out_log.push_back(mq.pop_front());
      if (bus.o_handshake_recv && !prev_ack) begin
        mq.push_back(bus.i_data);
        m_recv = (m_recv + 1) % 65536;
      end
      prev_ack = bus.o_handshake_recv;
      check("count", 32'(bus.o_count), 32'(mq.size()));
      check("valid", 32'(bus.o_valid), 32'(mq.size() != 0));
      check("received", 32'(bus.o_received), 32'(m_recv));
      if (mq.size() != 0) check("head", 32'(bus.o_data), 32'(mq[0]));
      if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
      pop_pend = (mq.size() != 0) && bus.i_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic val, input string tag);
    for (int c = 0; c < 200 && bus.o_handshake_recv !== val; c++) tick();
    check(tag, 32'(bus.o_handshake_recv), 32'(val));
  endtask

  task automatic send(input logic [W-1:0] nonce, input int hold);
    bus.i_data      = nonce;
    bus.i_handshake = 1'b1;
    wait_ack(1'b1, "ack_rise");
    repeat (hold) tick();
    bus.i_handshake = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.i_data      = '0;
    bus.i_handshake = 1'b0;
    bus.i_ready     = 1'b0;
    rand_rdy        = 0;
    mon_en          = 0;
    max_cnt         = 0;
    model_clear();

    // Reset held with req already high: nothing may be acknowledged.
    bus.i_handshake = 1'b1;
    bus.i_data      = 7'h5A;
    repeat (3) tick();
    check("rst_ack", 32'(bus.o_handshake_recv), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_count", 32'(bus.o_count), 32'd0);
    check("rst_received", 32'(bus.o_received), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'd0);

    // Release: ack must rise exactly two cycles later; single transfer of 5A.
    rst    = 1'b1;
    mon_en = 1;
    tick();
    check("lat_rise_1", 32'(bus.o_handshake_recv), 32'd0);
    tick();
    check("lat_rise_2", 32'(bus.o_handshake_recv), 32'd1);
    check("single_data", 32'(bus.o_data), 32'h5A);
    check("single_valid", 32'(bus.o_valid), 32'd1);
    check("single_count", 32'(bus.o_count), 32'd1);
    check("single_received", 32'(bus.o_received), 32'd1);
    bus.i_handshake = 1'b0;
    tick();
    check("lat_fall_1", 32'(bus.o_handshake_recv), 32'd1);
    tick();
    check("lat_fall_2", 32'(bus.o_handshake_recv), 32'd0);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check("drain_single", 32'(bus.o_count), 32'd0);

    // Stuck request: held high long after ack, still one capture.
    bus.i_data      = 7'h33;
    bus.i_handshake = 1'b1;
    wait_ack(1'b1, "stuck_ack_rise");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stuck_ack_hold", 32'(bus.o_handshake_recv), 32'd1);
      check("stuck_count", 32'(bus.o_count), 32'd1);
    end
    check("stuck_received", 32'(bus.o_received), 32'd2);
    bus.i_handshake = 1'b0;
    wait_ack(1'b0, "stuck_ack_fall");
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Back-pressure: fill with 1..4, fifth request must wait for a pop.
    for (int v = 1; v <= 4; v++) send(W'(v), 0);
    check("bp_full_count", 32'(bus.o_count), 32'd4);
    bus.i_data      = 7'd5;
    bus.i_handshake = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_no_ack", 32'(bus.o_handshake_recv), 32'd0);
    end
    check("bp_head", 32'(bus.o_data), 32'd1);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check("bp_no_ack_pop_cycle", 32'(bus.o_handshake_recv), 32'd0);
    tick();
    check("bp_ack_after_pop", 32'(bus.o_handshake_recv), 32'd1);
    check("bp_count_refill", 32'(bus.o_count), 32'd4);
    bus.i_handshake = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    out_log.delete();
    bus.i_ready = 1'b1;
    repeat (6) tick();
    bus.i_ready = 1'b0;
    check("bp_drain_len", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("bp_order", (i < out_log.size()) ? 32'(out_log[i]) : 32'hFFFF, 32'(i + 2));
    end

    // Asynchronous reset while acknowledging with two entries buffered.
    send(7'h11, 0);
    bus.i_data      = 7'h22;
    bus.i_handshake = 1'b1;
    wait_ack(1'b1, "mid_ack_rise");
    check("mid_count", 32'(bus.o_count), 32'd2);
    #2;
    rst    = 1'b0;
    mon_en = 0;
    #1;
    check("arst_ack", 32'(bus.o_handshake_recv), 32'd0);
    check("arst_valid", 32'(bus.o_valid), 32'd0);
    check("arst_count", 32'(bus.o_count), 32'd0);
    check("arst_received", 32'(bus.o_received), 32'd0);
    bus.i_handshake = 1'b0;
    tick();
    rst = 1'b1;
    model_clear();
    mon_en = 1;

    // Concurrent: downstream always ready, ten back-to-back transfers.
    bus.i_ready = 1'b1;
    max_cnt     = 0;
    out_log.delete();
    for (int n = 0; n < 10; n++) send(W'(n), 0);
    repeat (4) tick();
    check("conc_max_count", 32'(max_cnt <= 1), 32'd1);
    check("conc_len", 32'(out_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("conc_order", (i < out_log.size()) ? 32'(out_log[i]) : 32'hFFFF, 32'(i));
    end
    check("conc_received", 32'(bus.o_received), 32'd10);

    // Randomized: random data, hold times, gaps and downstream stalls.
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      send(W'($urandom_range(0, 127)), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy    = 0;
    bus.i_ready = 1'b1;
    repeat (8) tick();
    check("rand_drained", 32'(bus.o_count), 32'd0);
    check("rand_received", 32'(bus.o_received), 32'd50);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_shuffle_handshake_receiver

// File: doc/shuffle_handshake_receiver.md
Name: shuffle_handshake_receiver

Overview:
- Receive end of the shuffle-stage nonce transfer.
- The upstream shuffle unloader presents a nonce on a data bus and runs a 4-phase req/ack handshake. This block captures each nonce, completes the handshake, buffers nonces in a small FIFO and presents them downstream on a valid/ready stream.
- Upstream's req→ack path has only one register, so this block owns req synchronisation and back-pressure.

Parameters:
- nonce_width, 7, width of the nonce bus.
- buffer_depth, 4, receive FIFO entries; power of 2, ≥2.
- sync_stages, 1, flops on i_handshake before use; 1..3.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- i_data  input  nonce_width  nonce from upstream; stable while i_handshake=1.
- i_handshake  input  1  upstream request (4-phase req).
- o_handshake_recv  output  1  acknowledge to upstream (4-phase ack).
- o_data  output  nonce_width  FIFO head nonce.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  downstream accepts o_data when o_valid&i_ready.
- o_count  output  $clog2(buffer_depth)+1  current FIFO occupancy.
- o_received  output  16  total nonces captured; wraps 0xFFFF→0.

Behaviour:
- Reset (rst=0, async): state=IDLE, o_handshake_recv=0, sync flops=0, FIFO empty, o_valid=0, o_data=0, o_count=0, o_received=0. Mid-transfer reset drops ack at once; upstream resolves via its own reset.
- req_s = i_handshake delayed by sync_stages flops.
- FSM (registered):
  - IDLE: if req_s=1 and full=0 → push i_data into FIFO, o_handshake_recv←1, o_received+1, go ACK.
  - IDLE, req_s=1 and full=1: stay, ack stays 0 (back-pressure).
  - ACK: hold ack=1. When req_s=0 → o_handshake_recv←0, go IDLE.
  - Illegal encoding → IDLE, ack 0.
- Exactly one push per req rising phase; a req held high after capture never causes a second push.
- Latency: i_handshake rise → ack rise = sync_stages+1 cycles (FIFO not full). i_handshake fall → ack fall = sync_stages+1 cycles.
- i_data is sampled in the IDLE push cycle. Upstream holds it from before req rises until after ack is seen, so no data sync is needed.
- FIFO is first-word-fall-through:
  - o_data = head entry, o_valid = (count≠0).
  - Pop when o_valid&i_ready; pop with o_valid=0 is ignored.
  - The full flag used for the push decision is the registered count==buffer_depth. A same-cycle pop does not free the slot for that cycle's push.
  - Simultaneous push+pop when not full: count unchanged, both occur.
- Pointers are $clog2(buffer_depth) bits and wrap naturally. Count never exceeds buffer_depth and never underflows.
- o_data after a pop that empties the FIFO: don't-care; checker must gate on o_valid.

Decomposition:
- Shared package (shuffle_pkg): handshake FSM state constants (IDLE=0, ACK=1); the nonce_width default shared with the unloader.
- One sub-module: shuffle_nonce_fifo.
  - Register-based FWFT FIFO with parameters nonce_width and buffer_depth.
  - Ports: push, din, pop, dout, count, full, empty.
  - Asynchronous active-low reset.
- Sync chain and FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 with i_handshake=1 → o_handshake_recv=0, o_valid=0, o_count=0, o_received=0. Release; with sync_stages=1, ack=1 exactly 2 cycles later.
- Single transfer: i_data=7'h5A, req high until ack, then low → one entry; o_data=7'h5A, o_valid=1, o_count=1, o_received=1. Ack falls 2 cycles after req falls.
- Stuck req: hold req=1 for 20 cycles after ack → still only 1 push, o_count=1, ack stays 1.
- Back-pressure: i_ready=0, depth 4, send 5 nonces 1..5 → the 5th req gets no ack, o_count=4. Pop one (o_data=1) → 5th acked the cycle after the pop at earliest; final FIFO order 2,3,4,5.
- Concurrent: i_ready=1 throughout, send 10 back-to-back nonces → output order 0..9, no loss or duplication, o_count≤1, o_received=10.
- Async reset mid-ACK: assert rst=0 while ack=1 and o_count=2 → ack, o_valid, o_count go 0 without waiting for a clock edge.
